// File: rtl/bb_pkg.sv
// bb_pkg: shared types and constants for the busy-beaver run controller and engines
package bb_pkg;
    typedef enum logic [1:0] {BB_IDLE, BB_CLEAR, BB_RUN, BB_DONE} bb_run_state_t;
    localparam logic [1:0] BB_ST_NONE    = 2'd0;
    localparam logic [1:0] BB_ST_HALTED  = 2'd1;
    localparam logic [1:0] BB_ST_LIMIT   = 2'd2;
    localparam logic [1:0] BB_ST_ABORTED = 2'd3;
    localparam int         BB_NUM_SYMS   = 5;
    localparam logic [2:0] BB_SYM_BLANK  = 3'd0;
    localparam logic       BB_DIR_L      = 1'b0;
    localparam logic       BB_DIR_R      = 1'b1;
endpackage

// File: rtl/bb_clear_sweep.sv
// bb_clear_sweep: tape clear address counter, restarted at 0 by start, flags the last address
module bb_clear_sweep #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          last
);
    always_ff @(posedge clk) begin
        if (!rst_n || start) addr <= '0;
        else if (en) addr <= addr + 1'b1;
    end
    assign last = &addr;
endmodule

// File: rtl/bb_run_ctrl.sv
// bb_run_ctrl: clears the engine tape, runs the engine and counts steps until halt, limit or abort
module bb_run_ctrl
    import bb_pkg::*;
#(
    parameter int TAPE_AW = 7,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               ack,
    input  logic [CNT_W-1:0]   step_limit,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic [CNT_W-1:0]   steps,
    output logic               eng_rst_n,
    output logic               eng_clr,
    output logic [TAPE_AW-1:0] eng_clr_addr,
    output logic               eng_step_en,
    input  logic               eng_halt
);
    bb_run_state_t    state, state_nx;
    logic [CNT_W-1:0] limit, limit_nx, steps_nx, steps_inc;
    logic [1:0]       status_nx;
    logic             go, clr_last;
    assign go = start && (state == BB_IDLE || state == BB_DONE);
    bb_clear_sweep #(.AW(TAPE_AW)) u_sweep (
        .clk   (clk),
        .rst_n (rst_n),
        .start (go),
        .en    (state == BB_CLEAR),
        .addr  (eng_clr_addr),
        .last  (clr_last)
    );
    always_comb begin
        state_nx  = state;
        limit_nx  = limit;
        steps_nx  = steps;
        status_nx = status;
        steps_inc = &steps ? steps : steps + 1'b1;
        case (state)
            BB_IDLE, BB_DONE: begin
                if (go) begin
                    state_nx  = BB_CLEAR;
                    limit_nx  = step_limit;
                    steps_nx  = '0;
                    status_nx = BB_ST_NONE;
                end else if (state == BB_DONE && ack) state_nx = BB_IDLE;
            end
            BB_CLEAR: begin
                if (abort) begin
                    state_nx  = BB_DONE;
                    status_nx = BB_ST_ABORTED;
                end else if (clr_last) state_nx = BB_RUN;
            end
            default: begin
                // every RUN cycle is a step, including the terminating one
                steps_nx = steps_inc;
                if (abort || eng_halt || (limit != '0 && steps_inc == limit)) state_nx = BB_DONE;
                status_nx = abort ? BB_ST_ABORTED : eng_halt ? BB_ST_HALTED :
                            (limit != '0 && steps_inc == limit) ? BB_ST_LIMIT : status;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= BB_IDLE;
            limit  <= '0;
            steps  <= '0;
            status <= BB_ST_NONE;
        end else begin
            state  <= state_nx;
            limit  <= limit_nx;
            steps  <= steps_nx;
            status <= status_nx;
        end
    end
    assign busy        = state == BB_CLEAR || state == BB_RUN;
    assign done        = state == BB_DONE;
    assign eng_clr     = state == BB_CLEAR;
    assign eng_step_en = state == BB_RUN;
    assign eng_rst_n   = state == BB_RUN || state == BB_DONE;
endmodule

// File: tb/tb_bb_run_ctrl.sv
// tb_bb_run_ctrl: directed vector bench with a stub engine that halts on its K-th step
module tb_bb_run_ctrl;
    localparam int AW = 3;
    localparam int CW = 8;
    logic          clk = 0, rst_n = 0, start = 0, abort = 0, ack = 0;
    logic [CW-1:0] step_limit = '0;
    logic          busy, done, eng_rst_n, eng_clr, eng_step_en, eng_halt;
    logic [1:0]    status;
    logic [CW-1:0] steps;
    logic [AW-1:0] eng_clr_addr;
    int            k_halt = 0, eng_cnt = 0, n_chk = 0, n_fail = 0;

    bb_run_ctrl #(.TAPE_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ack(ack),
        .step_limit(step_limit), .busy(busy), .done(done), .status(status),
        .steps(steps), .eng_rst_n(eng_rst_n), .eng_clr(eng_clr),
        .eng_clr_addr(eng_clr_addr), .eng_step_en(eng_step_en), .eng_halt(eng_halt)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (!eng_rst_n) eng_cnt <= 0;
        else if (eng_step_en) eng_cnt <= eng_cnt + 1;
    end
    assign eng_halt = eng_step_en && k_halt != 0 && eng_cnt == k_halt - 1;

    typedef struct {
        int limit;
        int k;
        int abort_at;
        int st;
        int stp;
    } vec_t;
    vec_t vt[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, " busy"}, int'(busy), 0);
        chk({name, " done"}, int'(done), 0);
        chk({name, " status"}, int'(status), 0);
        chk({name, " steps"}, int'(steps), 0);
        chk({name, " eng_rst_n"}, int'(eng_rst_n), 0);
        chk({name, " eng_clr"}, int'(eng_clr), 0);
        chk({name, " eng_clr_addr"}, int'(eng_clr_addr), 0);
        chk({name, " eng_step_en"}, int'(eng_step_en), 0);
    endtask

    task automatic do_start(input int limit, input int k);
        step_limit = CW'(limit);
        k_halt = k;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic sweep_check();
        for (int i = 0; i < (1 << AW); i++) begin
            chk("clr", int'(eng_clr), 1);
            chk("clr_addr", int'(eng_clr_addr), i);
            chk("clr busy", int'(busy), 1);
            chk("clr step_en", int'(eng_step_en), 0);
            tick();
        end
        chk("run step_en", int'(eng_step_en), 1);
        chk("run clr", int'(eng_clr), 0);
        chk("run steps0", int'(steps), 0);
    endtask

    task automatic wait_done(input int ab);
        int n = 0;
        while (!done && n < 400) begin
            abort = ab >= 0 && eng_step_en && int'(steps) == ab;
            tick();
            abort = 0;
            n++;
        end
        chk("done reached", int'(done), 1);
    endtask

    task automatic finish_check(input string name, input int st, input int stp);
        chk({name, " busy"}, int'(busy), 0);
        chk({name, " step_en"}, int'(eng_step_en), 0);
        chk({name, " eng_rst_n"}, int'(eng_rst_n), 1);
        chk({name, " status"}, int'(status), st);
        chk({name, " steps"}, int'(steps), stp);
    endtask

    task automatic do_ack();
        ack = 1;
        tick();
        ack = 0;
        chk("ack done", int'(done), 0);
        chk("ack busy", int'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 5, -1, 1, 5};
        vt[1] = '{10, 0, -1, 2, 10};
        vt[2] = '{5, 5, -1, 1, 5};
        vt[3] = '{0, 0, 4, 3, 5};
        vt[4] = '{1, 0, -1, 2, 1};
        vt[5] = '{3, 7, -1, 2, 3};
        vt[6] = '{0, 1, -1, 1, 1};
        vt[7] = '{0, 0, 255, 3, 255};
        vt[8] = '{255, 0, -1, 2, 255};

        rst_n = 0;
        start = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_reset_vals("reset");
        end
        start = 0;
        rst_n = 1;
        tick();
        chk_reset_vals("post reset");
        abort = 1;
        tick();
        abort = 0;
        chk("idle abort busy", int'(busy), 0);
        chk("idle abort done", int'(done), 0);

        foreach (vt[i]) begin
            do_start(vt[i].limit, vt[i].k);
            sweep_check();
            wait_done(vt[i].abort_at);
            finish_check($sformatf("vec%0d", i), vt[i].st, vt[i].stp);
            do_ack();
        end

        do_start(0, 0);
        repeat (3) tick();
        chk("abort clr addr", int'(eng_clr_addr), 3);
        abort = 1;
        tick();
        abort = 0;
        chk("abort clr done", int'(done), 1);
        chk("abort clr eng_clr", int'(eng_clr), 0);
        finish_check("abort clr", 3, 0);
        do_ack();

        do_start(0, 6);
        repeat (2) tick();
        start = 1;
        tick();
        start = 0;
        chk("busy start addr", int'(eng_clr_addr), 3);
        repeat (5) tick();
        chk("busy start run", int'(eng_step_en), 1);
        repeat (2) tick();
        start = 1;
        tick();
        start = 0;
        chk("busy start steps", int'(steps), 3);
        chk("busy start step_en", int'(eng_step_en), 1);
        wait_done(-1);
        finish_check("busy start", 1, 6);
        abort = 1;
        tick();
        abort = 0;
        chk("done abort status", int'(status), 1);
        chk("done abort done", int'(done), 1);

        step_limit = '0;
        k_halt = 0;
        start = 1;
        ack = 1;
        tick();
        start = 0;
        ack = 0;
        chk("start+ack busy", int'(busy), 1);
        chk("start+ack clr", int'(eng_clr), 1);
        chk("start+ack addr", int'(eng_clr_addr), 0);
        chk("start+ack steps", int'(steps), 0);
        chk("start+ack status", int'(status), 0);
        chk("start+ack done", int'(done), 0);
        repeat (8 + 3) tick();
        chk("mid run steps", int'(steps), 3);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk_reset_vals("mid run reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
